// File: rtl/dac_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dac_sweep_ctrl_pkg
//   Shared definitions for the threshold-DAC sweep sequencer: default
//   geometry of the code table and the sequencer state encoding.
// -----------------------------------------------------------------------------
package dac_sweep_ctrl_pkg;

    localparam int DEF_CODE_W        = 8;
    localparam int DEF_N_STEPS       = 10;
    localparam int DEF_ADDR_W        = 4;
    localparam int DEF_SETTLE_W      = 16;
    localparam int DEF_MEAS_PER_STEP = 4;
    localparam int DEF_TMO_CYC       = 1024;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_MEAS   = 3'd4,
        ST_WAITM  = 3'd5,
        ST_NEXT   = 3'd6,
        ST_DONE   = 3'd7
    } sweep_state_t;

endpackage

// File: rtl/dac_sweep_ctrl_code_table.sv
// -----------------------------------------------------------------------------
// dac_code_table
//   N_STEPS x CODE_W register file holding the DAC sweep codes.
//   Synchronous write, asynchronous read, cleared by reset.
// Ports
//   Clk    in  system clock
//   resn   in  asynchronous active-low reset (clears all entries)
//   we     in  write enable (already qualified by the caller)
//   waddr  in  write address; addresses >= N_STEPS are dropped
//   wdata  in  write data
//   raddr  in  read address; addresses >= N_STEPS read as 0
//   rdata  out read data (combinational)
// -----------------------------------------------------------------------------
module dac_code_table #(
    parameter int CODE_W  = 8,
    parameter int N_STEPS = 10,
    parameter int ADDR_W  = 4
) (
    input  logic              Clk,
    input  logic              resn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [CODE_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [CODE_W-1:0] rdata
);

    logic [CODE_W-1:0] mem [N_STEPS];

    always_ff @(posedge Clk or negedge resn) begin
        if (!resn) begin
            for (int i = 0; i < N_STEPS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_STEPS; i++) begin
                if (we && (waddr == ADDR_W'(i))) begin
                    mem[i] <= wdata;
                end
            end
        end
    end

    // Decoded read so an out-of-range address can never alias an entry.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_STEPS; i++) begin
            if (raddr == ADDR_W'(i)) begin
                rdata = mem[i];
            end
        end
    end

endmodule

// File: rtl/dac_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dac_sweep_ctrl
//   Sequencer for the sigma-delta threshold DAC. Clears the accumulator, then
//   steps through the code table: load a code, wait the settle time, run
//   MEAS_PER_STEP measurement handshakes with the TDC readout, advance.
// Ports
//   Clk         in  system clock
//   resn        in  asynchronous active-low reset
//   start       in  1-cycle pulse, begins a sweep from IDLE
//   abort       in  level, abandons a sweep (beats start and meas_done)
//   tbl_we      in  table write strobe (IDLE only)
//   tbl_addr    in  table write address
//   tbl_data    in  table write data
//   settle_cyc  in  settle cycles per step, sampled at start (0 acts as 1)
//   meas_done   in  readout completion pulse, used only while waiting
//   dac_code    out registered DAC code
//   dac_load    out 1-cycle DAC latch strobe
//   dac_clr     out 1-cycle accumulator clear strobe
//   meas_start  out 1-cycle measurement request
//   step_idx    out current table index
//   busy        out high whenever not IDLE
//   sweep_done  out 1-cycle pulse on normal completion
//   tmo_err     out sticky measurement-timeout flag, cleared by start
// -----------------------------------------------------------------------------
module dac_sweep_ctrl
    import dac_sweep_ctrl_pkg::*;
#(
    parameter int CODE_W        = DEF_CODE_W,
    parameter int N_STEPS       = DEF_N_STEPS,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int SETTLE_W      = DEF_SETTLE_W,
    parameter int MEAS_PER_STEP = DEF_MEAS_PER_STEP,
    parameter int TMO_CYC       = DEF_TMO_CYC
) (
    input  logic                Clk,
    input  logic                resn,
    input  logic                start,
    input  logic                abort,
    input  logic                tbl_we,
    input  logic [ADDR_W-1:0]   tbl_addr,
    input  logic [CODE_W-1:0]   tbl_data,
    input  logic [SETTLE_W-1:0] settle_cyc,
    input  logic                meas_done,
    output logic [CODE_W-1:0]   dac_code,
    output logic                dac_load,
    output logic                dac_clr,
    output logic                meas_start,
    output logic [ADDR_W-1:0]   step_idx,
    output logic                busy,
    output logic                sweep_done,
    output logic                tmo_err
);

    localparam int MCNT_W = $clog2(MEAS_PER_STEP + 1);
    localparam int TMO_W  = $clog2(TMO_CYC + 1);

    localparam logic [MCNT_W-1:0] MEAS_LAST = MCNT_W'(MEAS_PER_STEP);
    localparam logic [ADDR_W-1:0] STEP_LAST = ADDR_W'(N_STEPS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO_CYC - 1);

    sweep_state_t        state_reg, state_next;
    logic [ADDR_W-1:0]   step_reg, step_next;
    logic [MCNT_W-1:0]   meas_cnt_reg, meas_cnt_next;
    logic [SETTLE_W-1:0] settle_val_reg, settle_val_next;
    logic [SETTLE_W-1:0] settle_cnt_reg, settle_cnt_next;
    logic [TMO_W-1:0]    tmo_cnt_reg, tmo_cnt_next;
    logic                aborting_reg, aborting_next;
    logic                tmo_err_reg, tmo_err_next;
    logic [CODE_W-1:0]   code_reg, code_next;
    logic                clr_reg, load_reg, mstart_reg, done_reg, busy_reg;

    logic                table_we;
    logic [CODE_W-1:0]   table_code;
    logic                abort_hit;

    // The table is only writable while idle so a running sweep sees a
    // stable set of codes.
    assign table_we = tbl_we && (state_reg == ST_IDLE);

    // Read port follows the index the next LOAD will use, so the code
    // register and the load strobe update on the same edge.
    dac_code_table #(
        .CODE_W  (CODE_W),
        .N_STEPS (N_STEPS),
        .ADDR_W  (ADDR_W)
    ) u_table (
        .Clk   (Clk),
        .resn  (resn),
        .we    (table_we),
        .waddr (tbl_addr),
        .wdata (tbl_data),
        .raddr (step_next),
        .rdata (table_code)
    );

    // Once the abort clear pulse is under way, a still-high abort level must
    // not re-enter CLEAR, otherwise a held abort would never reach IDLE.
    assign abort_hit = abort && (state_reg != ST_IDLE) &&
                       !((state_reg == ST_CLEAR) && aborting_reg);

    // Step index kept in its own process: it feeds the table read address,
    // which in turn feeds code_next in the main next-state process.
    always_comb begin
        step_next = step_reg;
        if ((state_reg == ST_IDLE) && start && !abort) begin
            step_next = '0;
        end else if ((state_reg == ST_NEXT) && !abort_hit && (step_reg != STEP_LAST)) begin
            step_next = step_reg + ADDR_W'(1);
        end
    end

    always_comb begin
        state_next      = state_reg;
        meas_cnt_next   = meas_cnt_reg;
        settle_val_next = settle_val_reg;
        settle_cnt_next = settle_cnt_reg;
        tmo_cnt_next    = tmo_cnt_reg;
        tmo_err_next    = tmo_err_reg;
        aborting_next   = aborting_reg;
        code_next       = code_reg;

        if (abort_hit) begin
            state_next    = ST_CLEAR;
            aborting_next = 1'b1;
            code_next     = '0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_next      = ST_CLEAR;
                        settle_val_next = (settle_cyc == '0) ? SETTLE_W'(1) : settle_cyc;
                        meas_cnt_next   = '0;
                        tmo_err_next    = 1'b0;
                        aborting_next   = 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (aborting_reg) begin
                        state_next    = ST_IDLE;
                        aborting_next = 1'b0;
                    end else begin
                        state_next = ST_LOAD;
                        code_next  = table_code;
                    end
                end
                ST_LOAD: begin
                    state_next      = ST_SETTLE;
                    settle_cnt_next = SETTLE_W'(1);
                end
                ST_SETTLE: begin
                    // settle_cnt counts the SETTLE cycle being spent, 1-based.
                    if (settle_cnt_reg == settle_val_reg) begin
                        state_next = ST_MEAS;
                    end else begin
                        settle_cnt_next = settle_cnt_reg + SETTLE_W'(1);
                    end
                end
                ST_MEAS: begin
                    state_next    = ST_WAITM;
                    meas_cnt_next = meas_cnt_reg + MCNT_W'(1);
                    tmo_cnt_next  = '0;
                end
                ST_WAITM: begin
                    // A timeout is handled exactly like a completion, only
                    // flagged in tmo_err.
                    if (meas_done || (tmo_cnt_reg == TMO_LAST)) begin
                        if (!meas_done) begin
                            tmo_err_next = 1'b1;
                        end
                        state_next = (meas_cnt_reg < MEAS_LAST) ? ST_MEAS : ST_NEXT;
                    end else begin
                        tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                    end
                end
                ST_NEXT: begin
                    if (step_reg == STEP_LAST) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next    = ST_LOAD;
                        meas_cnt_next = '0;
                        code_next     = table_code;
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge resn) begin
        if (!resn) begin
            state_reg      <= ST_IDLE;
            step_reg       <= '0;
            meas_cnt_reg   <= '0;
            settle_val_reg <= '0;
            settle_cnt_reg <= '0;
            tmo_cnt_reg    <= '0;
            aborting_reg   <= 1'b0;
            tmo_err_reg    <= 1'b0;
            code_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            step_reg       <= step_next;
            meas_cnt_reg   <= meas_cnt_next;
            settle_val_reg <= settle_val_next;
            settle_cnt_reg <= settle_cnt_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            aborting_reg   <= aborting_next;
            tmo_err_reg    <= tmo_err_next;
            code_reg       <= code_next;
        end
    end

    // Strobes are decoded from the next state and registered, so they are
    // glitch-free and line up exactly with the state they belong to.
    always_ff @(posedge Clk or negedge resn) begin
        if (!resn) begin
            clr_reg    <= 1'b0;
            load_reg   <= 1'b0;
            mstart_reg <= 1'b0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            clr_reg    <= (state_next == ST_CLEAR);
            load_reg   <= (state_next == ST_LOAD);
            mstart_reg <= (state_next == ST_MEAS);
            done_reg   <= (state_next == ST_DONE);
            busy_reg   <= (state_next != ST_IDLE);
        end
    end

    assign dac_code   = code_reg;
    assign dac_load   = load_reg;
    assign dac_clr    = clr_reg;
    assign meas_start = mstart_reg;
    assign step_idx   = step_reg;
    assign busy       = busy_reg;
    assign sweep_done = done_reg;
    assign tmo_err    = tmo_err_reg;

endmodule

// File: tb/tb_dac_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dac_sweep_ctrl
//   Self-checking bench for dac_sweep_ctrl. Each sweep is predicted as a
//   timeline of event cycles (clear, loads, measurement requests, done)
//   computed arithmetically from the settle time and the readout delays the
//   bench itself chooses, then compared against the events observed.
// -----------------------------------------------------------------------------
module tb_dac_sweep_ctrl;

    localparam int CODE_W   = 8;
    localparam int N_STEPS  = 10;
    localparam int ADDR_W   = 4;
    localparam int SETTLE_W = 16;
    localparam int MPS      = 4;
    localparam int TMO      = 1024;
    localparam int N_MEAS   = N_STEPS * MPS;

    logic                Clk = 1'b0;
    logic                resn;
    logic                start;
    logic                abort;
    logic                tbl_we;
    logic [ADDR_W-1:0]   tbl_addr;
    logic [CODE_W-1:0]   tbl_data;
    logic [SETTLE_W-1:0] settle_cyc;
    logic                meas_done;
    logic [CODE_W-1:0]   dac_code;
    logic                dac_load;
    logic                dac_clr;
    logic                meas_start;
    logic [ADDR_W-1:0]   step_idx;
    logic                busy;
    logic                sweep_done;
    logic                tmo_err;

    dac_sweep_ctrl #(
        .CODE_W        (CODE_W),
        .N_STEPS       (N_STEPS),
        .ADDR_W        (ADDR_W),
        .SETTLE_W      (SETTLE_W),
        .MEAS_PER_STEP (MPS),
        .TMO_CYC       (TMO)
    ) dut (
        .Clk        (Clk),
        .resn       (resn),
        .start      (start),
        .abort      (abort),
        .tbl_we     (tbl_we),
        .tbl_addr   (tbl_addr),
        .tbl_data   (tbl_data),
        .settle_cyc (settle_cyc),
        .meas_done  (meas_done),
        .dac_code   (dac_code),
        .dac_load   (dac_load),
        .dac_clr    (dac_clr),
        .meas_start (meas_start),
        .step_idx   (step_idx),
        .busy       (busy),
        .sweep_done (sweep_done),
        .tmo_err    (tmo_err)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;
    int done_at  = -1;
    int ms_seen  = 0;
    int dly [N_MEAS];                 // readout delay per measurement, 0 = withheld
    logic [CODE_W-1:0] tbl_m [N_STEPS];

    int                act_load_c [$];
    logic [CODE_W-1:0] act_load_v [$];
    int                act_ms     [$];
    int                act_clr    [$];
    int                act_done   [$];

    task automatic check_value(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    // One clock: sample outputs 1ns after the edge, log events, and play the
    // readout side (meas_done after the chosen delay, occasional spurious
    // meas_done in the same cycle as meas_start).
    task automatic cyc();
        @(posedge Clk);
        #1;
        cyc_n++;
        if (dac_load === 1'b1) begin
            act_load_c.push_back(cyc_n);
            act_load_v.push_back(dac_code);
        end
        if (dac_clr === 1'b1)    act_clr.push_back(cyc_n);
        if (sweep_done === 1'b1) act_done.push_back(cyc_n);
        meas_done = 1'b0;
        if (meas_start === 1'b1) begin
            act_ms.push_back(cyc_n);
            if (ms_seen < N_MEAS && dly[ms_seen] > 0) done_at = cyc_n + dly[ms_seen];
            else done_at = -1;
            ms_seen++;
            if ($urandom_range(0, 1) == 1) meas_done = 1'b1;
        end else if (cyc_n == done_at) begin
            meas_done = 1'b1;
        end
    endtask

    task automatic clear_logs();
        act_load_c.delete();
        act_load_v.delete();
        act_ms.delete();
        act_clr.delete();
        act_done.delete();
        ms_seen = 0;
        done_at = -1;
    endtask

    // Loads tbl_m, then tries out-of-range addresses that must be dropped.
    task automatic write_table();
        for (int i = 0; i < N_STEPS; i++) begin
            tbl_we = 1'b1; tbl_addr = ADDR_W'(i); tbl_data = tbl_m[i];
            cyc();
        end
        for (int i = N_STEPS; i < (1 << ADDR_W); i++) begin
            tbl_we = 1'b1; tbl_addr = ADDR_W'(i); tbl_data = CODE_W'($urandom);
            cyc();
        end
        tbl_we = 1'b0;
        cyc();
    endtask

    task automatic run_sweep(input int settle_in, input int hold_step, input int abort_ms, input bit misuse);
        int S, s, L, M, w, nl, nm, n, exp_done;
        int exp_load [N_STEPS];
        int exp_ms   [N_MEAS];
        bit aborted;
        bit exp_tmo;

        for (int i = 0; i < N_MEAS; i++) begin
            dly[i] = ((i / MPS) == hold_step) ? 0 : int'($urandom_range(1, 4));
        end
        if (abort_ms >= 0) dly[abort_ms] = 0;
        clear_logs();

        settle_cyc = SETTLE_W'(settle_in);
        start = 1'b1;
        cyc();
        start = 1'b0;
        s = cyc_n;
        check_value("start_busy", int'(busy), 1);
        check_value("start_tmo_clear", int'(tmo_err), 0);

        // Expected timeline from the sequencing rules.
        S = (settle_in == 0) ? 1 : settle_in;
        L = s + 1;
        w = 0;
        for (int i = 0; i < N_STEPS; i++) begin
            exp_load[i] = L;
            M = L + S + 1;
            for (int m = 0; m < MPS; m++) begin
                exp_ms[i*MPS+m] = M;
                w = (dly[i*MPS+m] == 0) ? M + TMO : M + dly[i*MPS+m];
                M = w + 1;
            end
            L = w + 2;
        end
        exp_done = L;
        exp_tmo  = (hold_step >= 0);

        aborted = 1'b0;
        n = 0;
        while (n < 12000) begin
            if (misuse && cyc_n == s + 3) begin
                tbl_we = 1'b1; tbl_addr = 2; tbl_data = ~tbl_m[2]; start = 1'b1;
            end
            if (abort_ms >= 0 && !aborted && act_ms.size() > abort_ms &&
                cyc_n == act_ms[abort_ms] + 1) begin
                abort = 1'b1; meas_done = 1'b1; aborted = 1'b1;
            end
            cyc();
            n++;
            tbl_we = 1'b0; start = 1'b0; abort = 1'b0;
            if (sweep_done === 1'b1) break;
            if (aborted && busy === 1'b0) break;
        end
        if (n >= 12000) check_value("sweep_budget_expired", n, 0);

        nl = aborted ? (abort_ms / MPS + 1) : N_STEPS;
        nm = aborted ? (abort_ms + 1) : N_MEAS;
        check_value("load_count", act_load_c.size(), nl);
        for (int i = 0; i < nl && i < act_load_c.size(); i++) begin
            check_value($sformatf("load%0d_cycle", i), act_load_c[i], exp_load[i]);
            check_value($sformatf("load%0d_code", i), int'(act_load_v[i]), int'(tbl_m[i]));
        end
        check_value("meas_start_count", act_ms.size(), nm);
        for (int i = 0; i < nm && i < act_ms.size(); i++) begin
            check_value($sformatf("meas%0d_cycle", i), act_ms[i], exp_ms[i]);
        end
        check_value("clr_count", act_clr.size(), aborted ? 2 : 1);
        if (act_clr.size() > 0) check_value("clr_latency", act_clr[0], s);

        if (aborted) begin
            if (act_clr.size() > 1) check_value("abort_clr_cycle", act_clr[1], exp_ms[abort_ms] + 2);
            check_value("abort_idle_cycle", cyc_n, exp_ms[abort_ms] + 3);
            check_value("abort_step_idx", int'(step_idx), abort_ms / MPS);
            check_value("abort_dac_code", int'(dac_code), 0);
            repeat (5) cyc();
            check_value("abort_no_done", act_done.size(), 0);
            check_value("abort_clr_settled", act_clr.size(), 2);
            check_value("abort_busy_low", int'(busy), 0);
        end else begin
            check_value("done_count", act_done.size(), 1);
            if (act_done.size() > 0) check_value("done_cycle", act_done[0], exp_done);
            check_value("done_busy", int'(busy), 1);
            check_value("done_tmo_err", int'(tmo_err), int'(exp_tmo));
            check_value("done_step_idx", int'(step_idx), N_STEPS - 1);
            check_value("done_dac_code", int'(dac_code), int'(tbl_m[N_STEPS-1]));
            cyc();
            check_value("after_done_busy", int'(busy), 0);
        end
        $display("sweep settle=%0d hold_step=%0d abort_meas=%0d misuse=%0d loads=%0d meas=%0d clr=%0d done=%0d",
                 settle_in, hold_step, abort_ms, misuse, act_load_c.size(), act_ms.size(),
                 act_clr.size(), act_done.size());
    endtask

    initial begin
        resn = 1'b0; start = 1'b0; abort = 1'b0; tbl_we = 1'b0;
        tbl_addr = '0; tbl_data = '0; settle_cyc = '0; meas_done = 1'b0;
        for (int i = 0; i < N_MEAS; i++) dly[i] = 1;

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        check_value("reset_outputs",
                    int'({dac_code, dac_load, dac_clr, meas_start, step_idx, busy, sweep_done, tmo_err}), 0);
        #3 resn = 1'b1;
        cyc();

        // Normal sweep with the reference code pattern, settle 5
        for (int i = 0; i < N_STEPS; i++) tbl_m[i] = (i == 0) ? CODE_W'(40) : CODE_W'(4 * (i + 1));
        write_table();
        run_sweep(5, -1, -1, 1'b0);

        // settle_cyc = 0 behaves as 1, random codes
        for (int i = 0; i < N_STEPS; i++) tbl_m[i] = CODE_W'($urandom);
        write_table();
        run_sweep(0, -1, -1, 1'b0);

        // Readout withheld at step 3: timeouts, sweep still completes
        for (int i = 0; i < N_STEPS; i++) tbl_m[i] = CODE_W'($urandom);
        write_table();
        run_sweep(int'($urandom_range(1, 6)), 3, -1, 1'b0);

        // Abort in WAITM at step 5 with a coincident meas_done
        run_sweep(int'($urandom_range(1, 6)), -1, 5 * MPS, 1'b0);

        // Table write and start while busy must have no effect
        for (int i = 0; i < N_STEPS; i++) tbl_m[i] = CODE_W'($urandom);
        write_table();
        run_sweep(3, -1, -1, 1'b1);

        // meas_done in IDLE and start+abort together in IDLE
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            meas_done = 1'b1;
            cyc();
        end
        start = 1'b1; abort = 1'b1;
        cyc();
        start = 1'b0; abort = 1'b0;
        repeat (4) cyc();
        check_value("idle_busy", int'(busy), 0);
        check_value("idle_no_clr", act_clr.size(), 0);
        check_value("idle_no_meas", act_ms.size(), 0);
        run_sweep(2, -1, -1, 1'b0);

        // Reset in the middle of a sweep clears outputs and table
        settle_cyc = 2;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (25) cyc();
        #3 resn = 1'b0;
        #1;
        check_value("mid_reset_outputs",
                    int'({dac_code, dac_load, dac_clr, meas_start, step_idx, busy, sweep_done, tmo_err}), 0);
        meas_done = 1'b0;
        done_at = -1;
        repeat (2) @(posedge Clk);
        #4 resn = 1'b1;
        cyc();
        for (int i = 0; i < N_STEPS; i++) tbl_m[i] = '0;
        run_sweep(4, -1, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
